memory_responder: RTL and testbench

Responder end of the CPU memory interface. Each cycle it samples the CPU's `memory_address`, `memory_write_enable` and `memory_write_data`, and services the access. The target is either on-chip word RAM or one of a small set of memory-mapped I/O registers: LEDs, synchronized switches, a free-running timer, and a 4-deep output FIFO drained by an external consumer over valid/ready. It sits beside `cpu` at the top level and drives `memory_read_data` back to it.

---
 rtl/memory_map_pkg.sv | 35 +++
 rtl/output_fifo.sv | 62 ++++++
 rtl/memory_responder.sv | 116 +++++++++++
 tb/tb_memory_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_map_pkg.sv
// Shared memory map for the CPU memory interface: I/O register addresses,
// STATUS bit layout and the word width. CPU-side test programs import this too.
package memory_map_pkg;

  localparam int WORD_W  = 16;
  localparam int COUNT_W = 3;

  localparam logic [WORD_W-1:0] LED_ADDR    = 16'hFFF0;
  localparam logic [WORD_W-1:0] SWITCH_ADDR = 16'hFFF1;
  localparam logic [WORD_W-1:0] TIMER_ADDR  = 16'hFFF2;
  localparam logic [WORD_W-1:0] FIFO_ADDR   = 16'hFFF3;
  localparam logic [WORD_W-1:0] STATUS_ADDR = 16'hFFF4;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_COUNT_LSB    = 2;
  localparam int STATUS_COUNT_MSB    = 4;
  localparam int STATUS_OVERFLOW_BIT = 5;

  function automatic logic [WORD_W-1:0] pack_status(
    input logic               full,
    input logic               empty,
    input logic [COUNT_W-1:0] count,
    input logic               overflow
  );
    logic [WORD_W-1:0] s;
    s = '0;
    s[STATUS_FULL_BIT]                    = full;
    s[STATUS_EMPTY_BIT]                   = empty;
    s[STATUS_COUNT_MSB:STATUS_COUNT_LSB]  = count;
    s[STATUS_OVERFLOW_BIT]                = overflow;
    return s;
  endfunction

endpackage

// File: rtl/output_fifo.sv
// Small output FIFO feeding an external valid/ready consumer. Reports rejected
// pushes via overflow_set; the sticky flag itself lives in the owner.
module output_fifo
  import memory_map_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [WORD_W-1:0]  push_data,
  input  logic               pop,
  output logic [WORD_W-1:0]  head,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               overflow_set
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WORD_W-1:0]  slot_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push_ok, pop_ok;

  assign full  = (count_q == COUNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = slot_q[rd_ptr_q];

  always_comb begin
    pop_ok       = pop && !empty;
    // a pop in the same cycle frees the slot a full FIFO needs
    push_ok      = push && (!full || pop_ok);
    overflow_set = push && !push_ok;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + COUNT_W'(push_ok) - COUNT_W'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) slot_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/memory_responder.sv
// Responder end of the CPU memory bus: word RAM plus LED, switch, timer,
// output FIFO and status registers, all with one-cycle registered reads.
module memory_responder
  import memory_map_pkg::*;
#(
  parameter int    RAM_ADDR_WIDTH = 10,
  parameter string INIT_FILE      = "",
  parameter int    FIFO_DEPTH     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memory_write_enable,
  input  logic [WORD_W-1:0] memory_address,
  input  logic [WORD_W-1:0] memory_write_data,
  output logic [WORD_W-1:0] memory_read_data,
  input  logic [WORD_W-1:0] switches,
  output logic [WORD_W-1:0] leds,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_WIDTH;

  logic [WORD_W-1:0]         mem_q [RAM_WORDS];
  logic [WORD_W-1:0]         ram_rd_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  logic hit_ram, hit_led, hit_switch, hit_timer, hit_fifo, hit_status;
  logic ram_we, fifo_push, fifo_pop;

  logic [WORD_W-1:0]  leds_q, leds_d;
  logic [WORD_W-1:0]  timer_q, timer_d;
  logic [WORD_W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic               overflow_q, overflow_d;
  logic [WORD_W-1:0]  io_rd_q, io_rd_d;
  logic               rd_ram_q, rd_ram_d;

  logic [COUNT_W-1:0] fifo_count;
  logic               fifo_full, fifo_empty, fifo_overflow_set;

  assign hit_ram    = ({1'b0, memory_address} < 17'(RAM_WORDS));
  assign hit_led    = (memory_address == LED_ADDR);
  assign hit_switch = (memory_address == SWITCH_ADDR);
  assign hit_timer  = (memory_address == TIMER_ADDR);
  assign hit_fifo   = (memory_address == FIFO_ADDR);
  assign hit_status = (memory_address == STATUS_ADDR);
  assign ram_idx    = memory_address[RAM_ADDR_WIDTH-1:0];

  // RAM keeps accepting writes through reset; only the register file is flushed
  assign ram_we    = memory_write_enable && hit_ram;
  assign fifo_push = memory_write_enable && hit_fifo && !reset;
  assign fifo_pop  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (ram_we) mem_q[ram_idx] <= memory_write_data;
    ram_rd_q <= mem_q[ram_idx];
  end

  output_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_output_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (fifo_push),
    .push_data   (memory_write_data),
    .pop         (fifo_pop),
    .head        (out_data),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .overflow_set(fifo_overflow_set)
  );

  assign out_valid = !fifo_empty;

  always_comb begin
    leds_d     = (memory_write_enable && hit_led) ? memory_write_data : leds_q;
    timer_d    = (memory_write_enable && hit_timer) ? '0 : timer_q + 1'b1;
    sync1_d    = switches;
    sync2_d    = sync1_q;
    overflow_d = (memory_write_enable && hit_status) ? 1'b0
                                                     : (overflow_q | fifo_overflow_set);
    rd_ram_d   = hit_ram;
    // reads see register values before this edge's writes
    io_rd_d    = '0;
    if (hit_led)         io_rd_d = leds_q;
    else if (hit_switch) io_rd_d = sync2_q;
    else if (hit_timer)  io_rd_d = timer_q;
    else if (hit_status) io_rd_d = pack_status(fifo_full, fifo_empty, fifo_count, overflow_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      leds_q     <= '0;
      timer_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      overflow_q <= 1'b0;
      io_rd_q    <= '0;
      rd_ram_q   <= 1'b0;
    end else begin
      leds_q     <= leds_d;
      timer_q    <= timer_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      overflow_q <= overflow_d;
      io_rd_q    <= io_rd_d;
      rd_ram_q   <= rd_ram_d;
    end
  end

  assign memory_read_data = rd_ram_q ? ram_rd_q : io_rd_q;
  assign leds             = leds_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: RAM, LED/unmapped, switch sync,
// FIFO fill/overflow/drain, push-with-pop when full, timer wrap, mid-run reset.
module tb_memory_responder;

  logic        clock;
  logic        reset;
  logic        memory_write_enable;
  logic [15:0] memory_address;
  logic [15:0] memory_write_data;
  logic [15:0] memory_read_data;
  logic [15:0] switches;
  logic [15:0] leds;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  memory_responder dut (
    .clock              (clock),
    .reset              (reset),
    .memory_write_enable(memory_write_enable),
    .memory_address     (memory_address),
    .memory_write_data  (memory_write_data),
    .memory_read_data   (memory_read_data),
    .switches           (switches),
    .leds               (leds),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] a, input logic [15:0] d);
    memory_write_enable = we;
    memory_address      = a;
    memory_write_data   = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    step();
    total++;
    if (memory_read_data !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata got=%h exp=%h", memory_read_data, 16'h0000);
    end
    total++;
    if (leds !== 16'h0000) begin
      bad++; $display("FAIL reset_leds got=%h exp=%h", leds, 16'h0000);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    reset = 1'b0;
    step();
    total++;
    if (memory_read_data !== 16'h0002) begin
      bad++; $display("FAIL reset_status got=%h exp=%h", memory_read_data, 16'h0002);
    end
  endtask

  task automatic test_ram();
    drive(1'b1, 16'h0005, 16'hBEEF);
    step();
    drive(1'b0, 16'h0005, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'hBEEF) begin
      bad++; $display("FAIL ram_read got=%h exp=%h", memory_read_data, 16'hBEEF);
    end
    drive(1'b1, 16'h0005, 16'h1111);
    step();
    total++;
    if (memory_read_data !== 16'hBEEF) begin
      bad++; $display("FAIL ram_rdw_old got=%h exp=%h", memory_read_data, 16'hBEEF);
    end
    drive(1'b0, 16'h0005, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h1111) begin
      bad++; $display("FAIL ram_rdw_new got=%h exp=%h", memory_read_data, 16'h1111);
    end
    drive(1'b1, 16'h03FF, 16'hCAFE);
    step();
    drive(1'b1, 16'h0000, 16'h0042);
    step();
    // one past the top of RAM must not alias onto word 0
    drive(1'b1, 16'h0400, 16'h7777);
    step();
    drive(1'b0, 16'h03FF, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'hCAFE) begin
      bad++; $display("FAIL ram_top got=%h exp=%h", memory_read_data, 16'hCAFE);
    end
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0042) begin
      bad++; $display("FAIL ram_no_alias got=%h exp=%h", memory_read_data, 16'h0042);
    end
    drive(1'b0, 16'h0400, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0000) begin
      bad++; $display("FAIL ram_above_range got=%h exp=%h", memory_read_data, 16'h0000);
    end
  endtask

  task automatic test_led_unmapped();
    drive(1'b1, 16'hFFF0, 16'h00A5);
    step();
    total++;
    if (leds !== 16'h00A5) begin
      bad++; $display("FAIL led_out got=%h exp=%h", leds, 16'h00A5);
    end
    total++;
    if (memory_read_data !== 16'h0000) begin
      bad++; $display("FAIL led_rdw_old got=%h exp=%h", memory_read_data, 16'h0000);
    end
    drive(1'b0, 16'hFFF0, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h00A5) begin
      bad++; $display("FAIL led_readback got=%h exp=%h", memory_read_data, 16'h00A5);
    end
    drive(1'b0, 16'h8000, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0000) begin
      bad++; $display("FAIL unmapped_read got=%h exp=%h", memory_read_data, 16'h0000);
    end
    drive(1'b1, 16'h8000, 16'h1234);
    step();
    drive(1'b0, 16'h8000, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0000 || leds !== 16'h00A5) begin
      bad++; $display("FAIL unmapped_write rdata=%h leds=%h exp=0000/00a5", memory_read_data, leds);
    end
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0002) begin
      bad++; $display("FAIL unmapped_status got=%h exp=%h", memory_read_data, 16'h0002);
    end
  endtask

  task automatic test_switch();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0000;
    exp_seq[1] = 16'h0000;
    exp_seq[2] = 16'h3C3C;
    drive(1'b0, 16'hFFF1, 16'h0000);
    step();
    switches = 16'h3C3C;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (memory_read_data !== exp_seq[i]) begin
        bad++; $display("FAIL switch_edge%0d got=%h exp=%h", i + 1, memory_read_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_fifo_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'hFFF3, 16'(i));
      step();
      if (i == 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
          bad++; $display("FAIL fifo_first_push valid=%b data=%h exp=1/0001", out_valid, out_data);
        end
      end
    end
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0011) begin
      bad++; $display("FAIL fifo_full_status got=%h exp=%h", memory_read_data, 16'h0011);
    end
    drive(1'b1, 16'hFFF3, 16'h0005);
    step();
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0031) begin
      bad++; $display("FAIL fifo_overflow_status got=%h exp=%h", memory_read_data, 16'h0031);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
        bad++; $display("FAIL fifo_drain%0d valid=%b data=%h exp=1/%h", k, out_valid, out_data, 16'(k));
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL fifo_drained_valid got=%b exp=0", out_valid);
    end
    step();
    total++;
    if (memory_read_data !== 16'h0022) begin
      bad++; $display("FAIL fifo_empty_ovf_status got=%h exp=%h", memory_read_data, 16'h0022);
    end
    out_ready = 1'b0;
    drive(1'b1, 16'hFFF4, 16'hABCD);
    step();
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0002) begin
      bad++; $display("FAIL fifo_ovf_clear got=%h exp=%h", memory_read_data, 16'h0002);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      drive(1'b1, 16'hFFF3, 16'(i));
      step();
    end
    out_ready = 1'b1;
    drive(1'b1, 16'hFFF3, 16'h0009);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0005) begin
      bad++; $display("FAIL b2b_head valid=%b data=%h exp=1/0005", out_valid, out_data);
    end
    step();
    out_ready = 1'b0;
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0011) begin
      bad++; $display("FAIL b2b_status got=%h exp=%h", memory_read_data, 16'h0011);
    end
    out_ready = 1'b1;
    drive(1'b0, 16'h8000, 16'h0000);
    for (int k = 6; k <= 9; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
        bad++; $display("FAIL b2b_drain%0d valid=%b data=%h exp=1/%h", k, out_valid, out_data, 16'(k));
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drained_valid got=%b exp=0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_timer();
    logic [15:0] exp_t;
    drive(1'b1, 16'hFFF2, 16'h0000);
    step();
    drive(1'b0, 16'hFFF2, 16'h0000);
    for (int i = 1; i <= 65537; i++) begin
      step();
      exp_t = 16'(i - 1);
      if (i == 1 || i == 2 || i == 3 || i == 65536 || i == 65537) begin
        total++;
        if (memory_read_data !== exp_t) begin
          bad++; $display("FAIL timer_read%0d got=%h exp=%h", i, memory_read_data, exp_t);
        end
      end
    end
    // count is now 1; a clear must win over the increment
    drive(1'b1, 16'hFFF2, 16'h5555);
    step();
    total++;
    if (memory_read_data !== 16'h0001) begin
      bad++; $display("FAIL timer_rdw_old got=%h exp=%h", memory_read_data, 16'h0001);
    end
    drive(1'b0, 16'hFFF2, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0000) begin
      bad++; $display("FAIL timer_clear got=%h exp=%h", memory_read_data, 16'h0000);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 16'hFFF3, 16'h0011);
    step();
    drive(1'b1, 16'hFFF3, 16'h0022);
    step();
    drive(1'b1, 16'hFFF0, 16'h5A5A);
    step();
    drive(1'b0, 16'hFFF0, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h5A5A || out_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset rdata=%h valid=%b exp=5a5a/1", memory_read_data, out_valid);
    end
    reset = 1'b1;
    drive(1'b1, 16'hFFF0, 16'hFFFF);
    step();
    total++;
    if (out_valid !== 1'b0 || leds !== 16'h0000 || memory_read_data !== 16'h0000) begin
      bad++; $display("FAIL mid_reset valid=%b leds=%h rdata=%h exp=0/0000/0000", out_valid, leds, memory_read_data);
    end
    drive(1'b1, 16'h0007, 16'h0777);
    step();
    drive(1'b1, 16'hFFF3, 16'h0099);
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_push_ignored valid=%b exp=0", out_valid);
    end
    reset = 1'b0;
    drive(1'b0, 16'h0007, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0777) begin
      bad++; $display("FAIL reset_ram_write got=%h exp=%h", memory_read_data, 16'h0777);
    end
    drive(1'b0, 16'hFFF4, 16'h0000);
    step();
    total++;
    if (memory_read_data !== 16'h0002) begin
      bad++; $display("FAIL reset_flush_status got=%h exp=%h", memory_read_data, 16'h0002);
    end
  endtask

  initial begin
    reset     = 1'b1;
    switches  = 16'h0000;
    out_ready = 1'b0;
    drive(1'b0, 16'h8000, 16'h0000);
    test_reset();
    test_ram();
    test_led_unmapped();
    test_switch();
    test_fifo_fill();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
